// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: req/ack handshake with a variable-latency data memory.
// Optional `MEM_TIMEOUT_EN adds a REQ watchdog that aborts with err_o after TIMEOUT_CYCLES.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [1:0]  dmem_size,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall_o,
    output logic [63:0] rdata_o,
    output logic        wb_valid_o,
    output logic        misalign_o,
    output logic        err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    state_e      state_q, state_d;
    logic        req_q, we_q;
    logic [63:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [2:0]  funct3_q;
    logic        killed_q, killed_d;
    logic        err_q, err_d;
    logic        access, misaligned, latch, timeout;
    logic [63:0] load_ext;

    assign access = (mem_rd | mem_wr) & ~flush;

    always_comb begin
        case (funct3[1:0])
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            2'd3:    misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{56{dmem_rdata[7]}}, dmem_rdata[7:0]};
            3'b001:  load_ext = {{48{dmem_rdata[15]}}, dmem_rdata[15:0]};
            3'b010:  load_ext = {{32{dmem_rdata[31]}}, dmem_rdata[31:0]};
            3'b011:  load_ext = dmem_rdata;
            3'b100:  load_ext = {56'd0, dmem_rdata[7:0]};
            3'b101:  load_ext = {48'd0, dmem_rdata[15:0]};
            3'b110:  load_ext = {32'd0, dmem_rdata[31:0]};
            default: load_ext = '0;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;

    // Fires on the TIMEOUT_CYCLES-th ack-less REQ cycle; a coincident ack wins.
    assign timeout = (state_q == StReq) && !dmem_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nrst || state_q != StReq) begin
            cnt_q <= '0;
        end else if (!dmem_ack) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        killed_d   = killed_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        latch      = 1'b0;
        stall_o    = 1'b0;
        wb_valid_o = 1'b0;
        misalign_o = 1'b0;
        rdata_o    = '0;
        unique case (state_q)
            StIdle: begin
                killed_d = 1'b0;
                if (access && !misaligned) begin
                    latch   = 1'b1;
                    stall_o = 1'b1;
                    state_d = StReq;
                end else if (access) begin
                    misalign_o = 1'b1;
                end else begin
                    wb_valid_o = 1'b1;
                end
            end
            StReq: begin
                stall_o  = 1'b1;
                // A flush cannot cancel the bus transaction, only its writeback.
                killed_d = killed_q | flush;
                if (dmem_ack) begin
                    rdata_d = we_q ? '0 : load_ext;
                    state_d = StDone;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                rdata_o    = rdata_q;
                wb_valid_o = !killed_q && !err_q;
                killed_d   = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (!nrst) begin
            stall_o    = 1'b0;
            wb_valid_o = 1'b0;
            misalign_o = 1'b0;
            rdata_o    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rdata_q  <= '0;
            killed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= (state_d == StReq);
            rdata_q  <= rdata_d;
            killed_q <= killed_d;
            err_q    <= err_d;
            if (latch) begin
                we_q     <= mem_wr;
                addr_q   <= addr;
                wdata_q  <= wdata;
                funct3_q <= funct3;
            end
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_size  = funct3_q[1:0];
    assign err_o      = err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer for the MEM stage of the RV64 pipeline. It takes the load/store request held in the EX/MEM register, runs a req/ack handshake with a variable-latency data memory, and holds IF..MEM with stall_o until the access completes. It then presents the extended load data and a writeback-valid qualifier. MEM/WB captures rdata_o, and its reg_wr input is ANDed with wb_valid_o, so a bubble is written while the access is pending.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN); legal range 2..255.

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
mem_rd  in  1  EX/MEM: load in MEM stage
mem_wr  in  1  EX/MEM: store in MEM stage
funct3  in  3  EX/MEM: load/store width and sign
addr  in  64  EX/MEM: ALU result, byte address
wdata  in  64  EX/MEM: store data (rs2)
flush  in  1  kill the instruction in MEM (trap/redirect)
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  64  byte address
dmem_wdata  out  64  store data, unshifted
dmem_size  out  2  funct3[1:0]: 0=B, 1=H, 2=W, 3=D
dmem_ack  in  1  one-cycle completion pulse
dmem_rdata  in  64  load data, LSB-aligned to addr, valid with ack
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
rdata_o  out  64  sign/zero-extended load data for MEM/WB
wb_valid_o  out  1  MEM/WB may take reg_wr this cycle
misalign_o  out  1  one-cycle pulse: misaligned access, no memory request
err_o  out  1  one-cycle pulse: timeout abort (MEM_TIMEOUT_EN only)

Behaviour:
- FSM states: IDLE, REQ, DONE. Encoding is free.
- IDLE:
  - access = (mem_rd|mem_wr) & ~flush.
  - If access and aligned: latch addr, wdata, funct3, we=mem_wr. Go to REQ. stall_o=1 combinationally in this cycle.
  - If access and misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0): no request. misalign_o=1 this cycle, wb_valid_o=0, stall_o=0, stay IDLE.
  - If no access: wb_valid_o=1, stall_o=0. Non-memory instructions pass with zero added latency.
- REQ:
  - dmem_req=1 (registered); dmem_* driven from latched values and stable until ack. stall_o=1, wb_valid_o=0.
  - On dmem_ack: capture the extended load data into rdata_q. Go to DONE.
- DONE (exactly 1 cycle):
  - stall_o=0. rdata_o=rdata_q. wb_valid_o = ~killed.
  - Next state is IDLE. The EX/MEM register advances on this edge, so the same instruction is never re-issued.
- Load extension (from latched funct3):
  - 000 LB: sign-extend bits [7:0].
  - 001 LH: sign-extend [15:0].
  - 010 LW: sign-extend [31:0].
  - 011 LD: take [63:0] as is.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: rdata 0.
  - Stores: rdata_q=0.
- Minimum access latency: request-detect cycle + 1 REQ cycle (ack on first REQ cycle) + DONE = 3 cycles of stall_o=1/0/… pattern, namely stall 2 cycles.
- Flush:
  - flush in IDLE suppresses the access entirely.
  - flush in REQ cannot cancel the bus transaction. Set killed=1, keep dmem_req until ack, then in DONE assert wb_valid_o=0.
  - killed clears on entry to IDLE.
- flush and ack in the same cycle: the ack completes the transaction and killed is still set for DONE.
- ack outside REQ is ignored.
- rdata_o outside DONE is 0.
- Reset (any state, including mid-REQ): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_size=0, rdata_q=0, killed=0, misalign_o=0, err_o=0. stall_o=0, and wb_valid_o=0 while nrst=0. A late ack after reset is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the next state is DONE: dmem_req drops, err_o pulses for 1 cycle, rdata_q=0, wb_valid_o=0 in DONE.
  - Ack on the same cycle as the timeout wins: normal completion, no err_o.
- Undefined: no counter. REQ waits indefinitely and err_o is tied 0.

Test Plan:
- LD to addr 0x1000, memory acks after 1 cycle with 0x8877665544332211 -> dmem_req high 1 cycle, stall_o high 2 cycles, DONE rdata_o=0x8877665544332211, wb_valid_o=1.
- LB / LBU to addr 0x2003, ack after 4 cycles with rdata 0x80 -> stall_o 5 cycles; rdata_o=0xFFFFFFFFFFFFFF80 for LB, 0x0000000000000080 for LBU.
- SW to addr 0x3002 -> misalign_o pulses 1 cycle, dmem_req never asserted, stall_o=0, wb_valid_o=0.
- LW issued, flush asserted in the 2nd REQ cycle, ack in the 3rd -> dmem_req held until ack, DONE wb_valid_o=0; next LW proceeds normally.
- nrst deasserted low during REQ, ack arrives the cycle after reset is released -> all outputs 0 during reset, FSM IDLE, late ack produces no DONE and no wb_valid pulse beyond the IDLE default.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 REQ cycles, err_o=1 for 1 cycle, wb_valid_o=0. Repeat with ack on the 4th cycle -> normal completion, err_o=0.
